// File: rtl/mul_latency_monitor_pkg.sv
// ---------------------------------------------------------------------------
// mul_latency_monitor_pkg
// Shared constants for the multiplier latency monitor and its FIFO.
//   SEL_W      : width of the statistics readout select
//   OCC_OUT_W  : width of the occupancy readout port
//   COUNT_W    : width of the completed-operation counter
//   occ_width(): bits needed to hold 0..depth inclusive
// ---------------------------------------------------------------------------
package mul_latency_monitor_pkg;

    localparam int SEL_W     = 3;
    localparam int OCC_OUT_W = 5;
    localparam int COUNT_W   = 32;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mul_latency_monitor_ts_fifo.sv
// ---------------------------------------------------------------------------
// mul_latency_monitor_ts_fifo
// Small in-order FIFO used for issue timestamps and for compare values.
// A push into a full FIFO is accepted only when a pop happens the same
// cycle; otherwise it is silently dropped (the caller raises the flag).
// A pop on an empty FIFO is ignored.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear, overrides push/pop
//   push/wdata: write request and data
//   pop       : remove the head entry
//   rdata     : current head entry (valid while occ != 0)
//   occ       : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mul_latency_monitor_ts_fifo
    import mul_latency_monitor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             do_push;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == (AW+1)'(DEPTH));
    assign do_pop   = pop && !is_empty && !clr;
    // A pop frees the slot this push needs, so full+pop still accepts.
    assign do_push  = push && (!is_full || do_pop) && !clr;

    assign rdata = mem[rd_ptr];
    assign occ   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mul_latency_monitor.sv
// ---------------------------------------------------------------------------
// mul_latency_monitor
// Latency and completion monitor for multiplier-class execution units.
// Each channel timestamps issues into an in-order FIFO and pops one
// timestamp per retire, accumulating count/total/min/max/last latency.
// Optional build macro: MUL_LATENCY_MONITOR_COMPARE_EN adds a result
// comparator between channel 0 and channel 1 retire values.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   clear_i             : synchronous clear of FIFOs, stats and flags
//   issue_valid_i       : per-channel issue strobe
//   retire_valid_i      : per-channel retire strobe
//   retire_value_i      : per-channel result, channel c at [c*DATA_W +: DATA_W]
//   stat_sel_i          : channel selected for readout
//   stat_*_o            : registered statistics of the selected channel
//   overflow_o          : sticky, an issue (or compare value) was dropped
//   underflow_o         : sticky, retire arrived with no outstanding issue
//   cmp_*_o             : comparator results (zero without the macro)
// ---------------------------------------------------------------------------
module mul_latency_monitor
    import mul_latency_monitor_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32,
    parameter int LAT_W      = 16,
    parameter int TOT_W      = 40,
    parameter int DATA_W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [CHANNELS-1:0]        issue_valid_i,
    input  logic [CHANNELS-1:0]        retire_valid_i,
    input  logic [CHANNELS*DATA_W-1:0] retire_value_i,
    input  logic [SEL_W-1:0]           stat_sel_i,
    output logic [COUNT_W-1:0]         stat_count_o,
    output logic [TOT_W-1:0]           stat_total_o,
    output logic [LAT_W-1:0]           stat_min_o,
    output logic [LAT_W-1:0]           stat_max_o,
    output logic [LAT_W-1:0]           stat_last_o,
    output logic [OCC_OUT_W-1:0]       stat_occ_o,
    output logic [CHANNELS-1:0]        overflow_o,
    output logic [CHANNELS-1:0]        underflow_o,
    output logic [31:0]                cmp_match_count_o,
    output logic                       cmp_mismatch_o,
    output logic [DATA_W-1:0]          cmp_bad_a_o,
    output logic [DATA_W-1:0]          cmp_bad_b_o
);

    localparam int OCC_W = occ_width(FIFO_DEPTH);
    // Saturation value for latency; also the reset value of min.
    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] now_q;

    logic [CHANNELS-1:0][CNT_W-1:0] head_ts;
    logic [CHANNELS-1:0][CNT_W-1:0] lat_diff;
    logic [CHANNELS-1:0][LAT_W-1:0] lat;
    logic [CHANNELS-1:0][TOT_W:0]   tot_sum;
    logic [CHANNELS-1:0][OCC_W-1:0] ts_occ;
    logic [CHANNELS-1:0]            ts_empty;
    logic [CHANNELS-1:0]            ts_full;

    logic [CHANNELS-1:0][COUNT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][TOT_W-1:0]   tot_q;
    logic [CHANNELS-1:0][LAT_W-1:0]   min_q;
    logic [CHANNELS-1:0][LAT_W-1:0]   max_q;
    logic [CHANNELS-1:0][LAT_W-1:0]   last_q;
    logic [CHANNELS-1:0]              ovf_q;
    logic [CHANNELS-1:0]              unf_q;
    logic [CHANNELS-1:0]              cmp_ovf;

    logic [COUNT_W-1:0]   sel_count;
    logic [TOT_W-1:0]     sel_total;
    logic [LAT_W-1:0]     sel_min;
    logic [LAT_W-1:0]     sel_max;
    logic [LAT_W-1:0]     sel_last;
    logic [OCC_OUT_W-1:0] sel_occ;

    logic unused_retire_value;
    assign unused_retire_value = ^retire_value_i;

    // Free-running timestamp source; clear does not disturb it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            now_q <= '0;
        end else begin
            now_q <= now_q + CNT_W'(1);
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < CHANNELS; gc++) begin : g_chan
            mul_latency_monitor_ts_fifo #(
                .WIDTH (CNT_W),
                .DEPTH (FIFO_DEPTH)
            ) u_ts_fifo (
                .clk   (clk_i),
                .rst   (rst_i),
                .clr   (clear_i),
                .push  (issue_valid_i[gc]),
                .pop   (retire_valid_i[gc]),
                .wdata (now_q),
                .rdata (head_ts[gc]),
                .occ   (ts_occ[gc])
            );

            assign ts_empty[gc] = (ts_occ[gc] == '0);
            assign ts_full[gc]  = (ts_occ[gc] == OCC_W'(FIFO_DEPTH));

            // Modular subtraction handles counter wrap between issue and retire.
            assign lat_diff[gc] = now_q - head_ts[gc];
            assign lat[gc]      = (lat_diff[gc] > CNT_W'(LAT_MAX)) ? LAT_MAX
                                                                  : LAT_W'(lat_diff[gc]);
            assign tot_sum[gc]  = {1'b0, tot_q[gc]} + (TOT_W+1)'(lat[gc]);
        end
    endgenerate

    // Per-channel statistics and sticky flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tot_q  <= '0;
            min_q  <= '1;
            max_q  <= '0;
            last_q <= '0;
            ovf_q  <= '0;
            unf_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            tot_q  <= '0;
            min_q  <= '1;
            max_q  <= '0;
            last_q <= '0;
            ovf_q  <= '0;
            unf_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (retire_valid_i[c] && !ts_empty[c]) begin
                    if (cnt_q[c] != '1) begin
                        cnt_q[c] <= cnt_q[c] + COUNT_W'(1);
                    end
                    tot_q[c] <= tot_sum[c][TOT_W] ? TOT_MAX : tot_sum[c][TOT_W-1:0];
                    if (lat[c] < min_q[c]) begin
                        min_q[c] <= lat[c];
                    end
                    if (lat[c] > max_q[c]) begin
                        max_q[c] <= lat[c];
                    end
                    last_q[c] <= lat[c];
                end
                if (retire_valid_i[c] && ts_empty[c]) begin
                    unf_q[c] <= 1'b1;
                end
                // A same-cycle retire frees a slot, so full+retire is not a drop.
                if ((issue_valid_i[c] && ts_full[c] && !retire_valid_i[c]) || cmp_ovf[c]) begin
                    ovf_q[c] <= 1'b1;
                end
            end
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // Readout mux; unmatched select codes fall through to zero.
    always_comb begin
        sel_count = '0;
        sel_total = '0;
        sel_min   = '0;
        sel_max   = '0;
        sel_last  = '0;
        sel_occ   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (stat_sel_i == SEL_W'(c)) begin
                sel_count = cnt_q[c];
                sel_total = tot_q[c];
                sel_min   = min_q[c];
                sel_max   = max_q[c];
                sel_last  = last_q[c];
                sel_occ   = OCC_OUT_W'(ts_occ[c]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_count_o <= '0;
            stat_total_o <= '0;
            stat_min_o   <= '0;
            stat_max_o   <= '0;
            stat_last_o  <= '0;
            stat_occ_o   <= '0;
        end else begin
            stat_count_o <= sel_count;
            stat_total_o <= sel_total;
            stat_min_o   <= sel_min;
            stat_max_o   <= sel_max;
            stat_last_o  <= sel_last;
            stat_occ_o   <= sel_occ;
        end
    end

`ifdef MUL_LATENCY_MONITOR_COMPARE_EN
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [OCC_W-1:0]  va_occ;
    logic [OCC_W-1:0]  vb_occ;
    logic              va_empty;
    logic              vb_empty;
    logic              va_full;
    logic              vb_full;
    logic              both_ready;
    logic              bypass;
    logic              cmp_fire;
    logic              push_a;
    logic              push_b;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [31:0]       match_q;
    logic              mism_q;
    logic [DATA_W-1:0] bad_a_q;
    logic [DATA_W-1:0] bad_b_q;

    assign val_a    = retire_value_i[0 +: DATA_W];
    assign val_b    = retire_value_i[DATA_W +: DATA_W];
    assign va_empty = (va_occ == '0);
    assign vb_empty = (vb_occ == '0);
    assign va_full  = (va_occ == OCC_W'(FIFO_DEPTH));
    assign vb_full  = (vb_occ == OCC_W'(FIFO_DEPTH));

    // Queued pairs are compared first; when nothing is queued and both
    // results arrive together they are compared straight from the inputs.
    assign both_ready = !va_empty && !vb_empty;
    assign bypass     = va_empty && vb_empty && retire_valid_i[0] && retire_valid_i[1];
    assign cmp_fire   = both_ready || bypass;
    assign cmp_a      = both_ready ? head_a : val_a;
    assign cmp_b      = both_ready ? head_b : val_b;
    assign push_a     = retire_valid_i[0] && !bypass;
    assign push_b     = retire_valid_i[1] && !bypass;

    mul_latency_monitor_ts_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_val_a_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (clear_i),
        .push  (push_a),
        .pop   (both_ready),
        .wdata (val_a),
        .rdata (head_a),
        .occ   (va_occ)
    );

    mul_latency_monitor_ts_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_val_b_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (clear_i),
        .push  (push_b),
        .pop   (both_ready),
        .wdata (val_b),
        .rdata (head_b),
        .occ   (vb_occ)
    );

    // Value FIFO drops are folded into the channel overflow flags.
    always_comb begin
        cmp_ovf    = '0;
        cmp_ovf[0] = push_a && va_full && !both_ready;
        cmp_ovf[1] = push_b && vb_full && !both_ready;
    end

    // Only the first mismatching pair is captured for debug.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            match_q <= '0;
            mism_q  <= 1'b0;
            bad_a_q <= '0;
            bad_b_q <= '0;
        end else if (clear_i) begin
            match_q <= '0;
            mism_q  <= 1'b0;
            bad_a_q <= '0;
            bad_b_q <= '0;
        end else if (cmp_fire) begin
            if (cmp_a == cmp_b) begin
                if (match_q != '1) begin
                    match_q <= match_q + 32'd1;
                end
            end else if (!mism_q) begin
                mism_q  <= 1'b1;
                bad_a_q <= cmp_a;
                bad_b_q <= cmp_b;
            end
        end
    end

    assign cmp_match_count_o = match_q;
    assign cmp_mismatch_o    = mism_q;
    assign cmp_bad_a_o       = bad_a_q;
    assign cmp_bad_b_o       = bad_b_q;
`else
    assign cmp_ovf           = '0;
    assign cmp_match_count_o = '0;
    assign cmp_mismatch_o    = 1'b0;
    assign cmp_bad_a_o       = '0;
    assign cmp_bad_b_o       = '0;
`endif

endmodule

// File: tb/tb_mul_latency_monitor.sv
// ---------------------------------------------------------------------------
// tb_mul_latency_monitor
// Self-checking bench for mul_latency_monitor with a small counter, short
// latency field and narrow total so wrap and saturation are reachable.
// A queue-based reference model tracks outstanding issue times per channel
// and derives every expected statistic from them.
// ---------------------------------------------------------------------------
module tb_mul_latency_monitor;

    localparam int CH      = 3;
    localparam int DEPTH   = 8;
    localparam int CW      = 8;
    localparam int LW      = 6;
    localparam int TW      = 12;
    localparam int DW      = 8;
    localparam int NOW_MOD = 1 << CW;
    localparam int LAT_SAT = (1 << LW) - 1;
    localparam int TOT_SAT = (1 << TW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clear = 1'b0;
    logic [CH-1:0]      issue_valid = '0;
    logic [CH-1:0]      retire_valid = '0;
    logic [CH*DW-1:0]   retire_value = '0;
    logic [2:0]         stat_sel = '0;
    logic [31:0]        stat_count;
    logic [TW-1:0]      stat_total;
    logic [LW-1:0]      stat_min;
    logic [LW-1:0]      stat_max;
    logic [LW-1:0]      stat_last;
    logic [4:0]         stat_occ;
    logic [CH-1:0]      overflow;
    logic [CH-1:0]      underflow;
    logic [31:0]        cmp_match_count;
    logic               cmp_mismatch;
    logic [DW-1:0]      cmp_bad_a;
    logic [DW-1:0]      cmp_bad_b;

    always #5 clk = ~clk;

    mul_latency_monitor #(
        .CHANNELS   (CH),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW),
        .LAT_W      (LW),
        .TOT_W      (TW),
        .DATA_W     (DW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .clear_i           (clear),
        .issue_valid_i     (issue_valid),
        .retire_valid_i    (retire_valid),
        .retire_value_i    (retire_value),
        .stat_sel_i        (stat_sel),
        .stat_count_o      (stat_count),
        .stat_total_o      (stat_total),
        .stat_min_o        (stat_min),
        .stat_max_o        (stat_max),
        .stat_last_o       (stat_last),
        .stat_occ_o        (stat_occ),
        .overflow_o        (overflow),
        .underflow_o       (underflow),
        .cmp_match_count_o (cmp_match_count),
        .cmp_mismatch_o    (cmp_mismatch),
        .cmp_bad_a_o       (cmp_bad_a),
        .cmp_bad_b_o       (cmp_bad_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int      ts_q [CH][$];
    longint  m_cnt [CH];
    int      m_tot [CH];
    int      m_min [CH];
    int      m_max [CH];
    int      m_last [CH];
    bit      m_ovf [CH];
    bit      m_unf [CH];
    int      m_now;
    int      vq [2][$];
    longint  m_match;
    bit      m_mism;
    int      m_bad_a;
    int      m_bad_b;
    // Expected registered readout
    longint  e_count;
    int      e_total, e_min, e_max, e_last, e_occ;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void modelClear();
        for (int c = 0; c < CH; c++) begin
            ts_q[c].delete();
            m_cnt[c]  = 0;
            m_tot[c]  = 0;
            m_min[c]  = LAT_SAT;
            m_max[c]  = 0;
            m_last[c] = 0;
            m_ovf[c]  = 0;
            m_unf[c]  = 0;
        end
        vq[0].delete();
        vq[1].delete();
        m_match = 0;
        m_mism  = 0;
        m_bad_a = 0;
        m_bad_b = 0;
    endfunction

    function automatic void modelReset();
        modelClear();
        m_now   = 0;
        e_count = 0;
        e_total = 0;
        e_min   = 0;
        e_max   = 0;
        e_last  = 0;
        e_occ   = 0;
    endfunction

    function automatic void comparePair(input int a, input int b);
        if (a == b) begin
            m_match++;
        end else if (!m_mism) begin
            m_mism  = 1;
            m_bad_a = a;
            m_bad_b = b;
        end
    endfunction

    // One clock edge of the reference behaviour.
    function automatic void modelStep(input logic [CH-1:0] iss, input logic [CH-1:0] ret,
                                      input logic clr, input logic [2:0] sel,
                                      input logic [CH*DW-1:0] vals);
        int ts, lat, a, b;
        if (int'(sel) < CH) begin
            e_count = m_cnt[sel];
            e_total = m_tot[sel];
            e_min   = m_min[sel];
            e_max   = m_max[sel];
            e_last  = m_last[sel];
            e_occ   = ts_q[sel].size();
        end else begin
            e_count = 0;
            e_total = 0;
            e_min   = 0;
            e_max   = 0;
            e_last  = 0;
            e_occ   = 0;
        end
        if (clr) begin
            modelClear();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (ret[c]) begin
                    if (ts_q[c].size() > 0) begin
                        ts  = ts_q[c].pop_front();
                        lat = (m_now - ts + NOW_MOD) % NOW_MOD;
                        if (lat > LAT_SAT) lat = LAT_SAT;
                        if (m_cnt[c] < 64'hFFFF_FFFF) m_cnt[c]++;
                        m_tot[c] = (m_tot[c] + lat > TOT_SAT) ? TOT_SAT : m_tot[c] + lat;
                        if (lat < m_min[c]) m_min[c] = lat;
                        if (lat > m_max[c]) m_max[c] = lat;
                        m_last[c] = lat;
                    end else begin
                        m_unf[c] = 1;
                    end
                end
                if (iss[c]) begin
                    if (ts_q[c].size() < DEPTH) ts_q[c].push_back(m_now);
                    else m_ovf[c] = 1;
                end
            end
`ifdef MUL_LATENCY_MONITOR_COMPARE_EN
            a = int'(vals[0 +: DW]);
            b = int'(vals[DW +: DW]);
            if (vq[0].size() == 0 && vq[1].size() == 0 && ret[0] && ret[1]) begin
                comparePair(a, b);
            end else begin
                if (vq[0].size() > 0 && vq[1].size() > 0) begin
                    comparePair(vq[0].pop_front(), vq[1].pop_front());
                end
                if (ret[0]) begin
                    if (vq[0].size() < DEPTH) vq[0].push_back(a);
                    else m_ovf[0] = 1;
                end
                if (ret[1]) begin
                    if (vq[1].size() < DEPTH) vq[1].push_back(b);
                    else m_ovf[1] = 1;
                end
            end
`else
            a = int'(vals[0 +: DW]);
            b = a;
`endif
        end
        m_now = (m_now + 1) % NOW_MOD;
    endfunction

    task automatic checkAll();
        logic [CH-1:0] eo, eu;
        for (int c = 0; c < CH; c++) begin
            eo[c] = m_ovf[c];
            eu[c] = m_unf[c];
        end
        checkOutput("count", stat_count, e_count);
        checkOutput("total", stat_total, e_total);
        checkOutput("min", stat_min, e_min);
        checkOutput("max", stat_max, e_max);
        checkOutput("last", stat_last, e_last);
        checkOutput("occ", stat_occ, e_occ);
        checkOutput("overflow", overflow, eo);
        checkOutput("underflow", underflow, eu);
        checkOutput("cmp_match", cmp_match_count, m_match);
        checkOutput("cmp_mismatch", cmp_mismatch, m_mism);
        checkOutput("cmp_bad_a", cmp_bad_a, m_bad_a);
        checkOutput("cmp_bad_b", cmp_bad_b, m_bad_b);
    endtask

    // Drives one cycle of inputs, advances the model and checks after the edge.
    task automatic applyStimulus(input logic [CH-1:0] iss, input logic [CH-1:0] ret,
                                 input logic clr, input logic [2:0] sel,
                                 input logic [CH*DW-1:0] vals);
        issue_valid  = iss;
        retire_valid = ret;
        clear        = clr;
        stat_sel     = sel;
        retire_value = vals;
        modelStep(iss, ret, clr, sel, vals);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input logic [2:0] sel);
        applyStimulus('0, '0, 1'b0, sel, '0);
    endtask

    task automatic doClear();
        applyStimulus('0, '0, 1'b1, 3'd0, '0);
    endtask

    initial begin
        logic [CH-1:0]    r_iss, r_ret;
        logic [CH*DW-1:0] r_val;
        logic             r_clr;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single op on channel 0: latency 3
        applyStimulus(3'b001, 3'b000, 1'b0, 3'd0, '0);
        idle(3'd0);
        idle(3'd0);
        applyStimulus(3'b000, 3'b001, 1'b0, 3'd0, '0);
        idle(3'd0);
        checkOutput("t1_count", stat_count, 64'd1);
        checkOutput("t1_total", stat_total, 64'd3);
        checkOutput("t1_min", stat_min, 64'd3);
        checkOutput("t1_max", stat_max, 64'd3);
        checkOutput("t1_last", stat_last, 64'd3);

        // Channel 1: issues at t0..t3, retires at t5, t7, t8, t20
        repeat (4) applyStimulus(3'b010, 3'b000, 1'b0, 3'd1, '0);
        idle(3'd1);
        applyStimulus(3'b000, 3'b010, 1'b0, 3'd1, '0);
        idle(3'd1);
        applyStimulus(3'b000, 3'b010, 1'b0, 3'd1, '0);
        applyStimulus(3'b000, 3'b010, 1'b0, 3'd1, '0);
        repeat (11) idle(3'd1);
        applyStimulus(3'b000, 3'b010, 1'b0, 3'd1, '0);
        idle(3'd1);
        checkOutput("t2_count", stat_count, 64'd4);
        checkOutput("t2_total", stat_total, 64'd34);
        checkOutput("t2_min", stat_min, 64'd5);
        checkOutput("t2_max", stat_max, 64'd17);
        checkOutput("t2_occ", stat_occ, 64'd0);

        // Overflow on channel 0, then issue+retire while full
        doClear();
        repeat (DEPTH + 1) applyStimulus(3'b001, 3'b000, 1'b0, 3'd0, '0);
        checkOutput("ovf_flag", overflow, 64'b001);
        applyStimulus(3'b001, 3'b001, 1'b0, 3'd0, '0);
        checkOutput("ovf_occ_full", stat_occ, DEPTH);
        idle(3'd0);
        checkOutput("ovf_occ_kept", stat_occ, DEPTH);
        checkOutput("ovf_no_unf", underflow, 64'b000);

        // Retire on empty channel 0 with same-cycle issue
        doClear();
        applyStimulus(3'b001, 3'b001, 1'b0, 3'd0, '0);
        idle(3'd0);
        checkOutput("unf_flag", underflow, 64'b001);
        checkOutput("unf_occ", stat_occ, 64'd1);
        checkOutput("unf_count", stat_count, 64'd0);

        // Latency across cycle counter wrap: issue at now=250, retire at now=4
        doClear();
        for (int i = 0; i < NOW_MOD && m_now != 250; i++) idle(3'd2);
        applyStimulus(3'b100, 3'b000, 1'b0, 3'd2, '0);
        for (int i = 0; i < NOW_MOD && m_now != 4; i++) idle(3'd2);
        applyStimulus(3'b000, 3'b100, 1'b0, 3'd2, '0);
        idle(3'd2);
        checkOutput("wrap_last", stat_last, 64'd10);

        // Latency saturation
        applyStimulus(3'b100, 3'b000, 1'b0, 3'd2, '0);
        repeat (70) idle(3'd2);
        applyStimulus(3'b000, 3'b100, 1'b0, 3'd2, '0);
        idle(3'd2);
        checkOutput("sat_last", stat_last, LAT_SAT);
        checkOutput("sat_total", stat_total, 64'd73);

`ifdef MUL_LATENCY_MONITOR_COMPARE_EN
        // Compare: 6/6 match, then 42 vs 41 mismatch
        doClear();
        applyStimulus(3'b000, 3'b011, 1'b0, 3'd0, {8'd0, 8'd6, 8'd6});
        applyStimulus(3'b000, 3'b001, 1'b0, 3'd0, {8'd0, 8'd0, 8'd42});
        applyStimulus(3'b000, 3'b010, 1'b0, 3'd0, {8'd0, 8'd41, 8'd0});
        idle(3'd0);
        checkOutput("cmp_match_n", cmp_match_count, 64'd1);
        checkOutput("cmp_mism_set", cmp_mismatch, 64'd1);
        checkOutput("cmp_bad_a_val", cmp_bad_a, 64'd42);
        checkOutput("cmp_bad_b_val", cmp_bad_b, 64'd41);
        doClear();
        checkOutput("cmp_clr_match", cmp_match_count, 64'd0);
        checkOutput("cmp_clr_mism", cmp_mismatch, 64'd0);
`endif

        // Randomized traffic including rare clears and invalid selects
        for (int i = 0; i < 600; i++) begin
            r_iss = CH'($urandom_range(0, (1 << CH) - 1));
            r_ret = CH'($urandom_range(0, (1 << CH) - 1)) & CH'($urandom_range(0, (1 << CH) - 1) | $urandom_range(0, (1 << CH) - 1));
            r_clr = ($urandom_range(0, 79) == 0);
            for (int c = 0; c < CH; c++) r_val[c*DW +: DW] = DW'($urandom_range(0, 3));
            applyStimulus(r_iss, r_ret, r_clr, 3'($urandom_range(0, 7)), r_val);
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) applyStimulus(3'b111, 3'b000, 1'b0, 3'd1, '0);
        issue_valid  = '0;
        retire_valid = '0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        idle(3'd1);
        idle(3'd1);
        checkOutput("post_rst_occ", stat_occ, 64'd0);
        checkOutput("post_rst_min", stat_min, LAT_SAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
